spi_master_tx: RTL and testbench

Transmit datapath of the SPI master; the transmit counterpart of the master receive path. It pulls 32-bit words from the TX FIFO over a valid/ready handshake and shifts them out MSB-first on sdo0 in standard mode, or on sdo3..sdo0 in quad mode. The shift is paced by tx_edge strobes from the SPI clock generator, and clk_en_o gates that generator. The block sits between the TX FIFO and the pad-side sdo lines, under control of the master controller (en, counter_in).

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_master_tx.sv | 121 ++++++++++++
 tb/tb_spi_master_tx.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transmit path.
// Word width, counter width and reset target live here.
package spi_pkg;

  localparam int SPI_WORD_W        = 32;
  localparam int SPI_CNT_W         = 16;
  localparam int QUAD_SYM_PER_WORD = 8;
  localparam int STD_SYM_PER_WORD  = 32;
  localparam logic [SPI_CNT_W-1:0] SPI_CNT_RST_TRGT = 16'd8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRANSMIT  = 2'd1,
    WAIT_FIFO = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_master_tx.sv
// SPI master transmit datapath: pops 32-bit FIFO words and
// shifts them MSB-first onto sdo0 (standard) or sdo3..sdo0 (quad).
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_WORD_W,
  parameter int CNT_W  = SPI_CNT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              tx_edge,
  output logic              tx_done,
  output logic              sdo0,
  output logic              sdo1,
  output logic              sdo2,
  output logic              sdo3,
  input  logic              en_quad_in,
  input  logic [CNT_W-1:0]  counter_in,
  input  logic              counter_in_upd,
  input  logic [DATA_W-1:0] data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              clk_en_o
);

  spi_state_e        r_state;
  spi_state_e        w_nxt;
  logic [CNT_W-1:0]  r_counter;
  logic [CNT_W-1:0]  r_trgt;
  logic [DATA_W-1:0] r_sr;

  logic w_done;
  logic w_word_end;
  logic w_load;
  logic w_shift;
  logic w_cnt_clr;

  assign w_word_end = en_quad_in ? (r_counter[2:0] == 3'd7)
                                 : (r_counter[4:0] == 5'd31);

  assign w_done = (r_state == TRANSMIT) && tx_edge &&
                  (r_counter == r_trgt - 1'b1);

  assign tx_done = w_done;

  assign sdo0 = en_quad_in ? r_sr[DATA_W-4] : r_sr[DATA_W-1];
  assign sdo1 = en_quad_in & r_sr[DATA_W-3];
  assign sdo2 = en_quad_in & r_sr[DATA_W-2];
  assign sdo3 = en_quad_in & r_sr[DATA_W-1];

  always_comb begin
    w_nxt      = r_state;
    data_ready = 1'b0;
    clk_en_o   = 1'b0;
    w_load     = 1'b0;
    w_shift    = 1'b0;
    w_cnt_clr  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (en && data_valid && (r_trgt != '0)) begin
          data_ready = 1'b1;
          w_load     = 1'b1;
          w_cnt_clr  = 1'b1;
          w_nxt      = TRANSMIT;
        end
      end
      TRANSMIT: begin
        clk_en_o = 1'b1;
        if (tx_edge) begin
          w_shift = 1'b1;
          // final edge wins: never fetch a word we will not send
          if (w_done) begin
            w_cnt_clr = 1'b1;
            w_nxt     = IDLE;
          end else if (w_word_end) begin
            if (data_valid) begin
              data_ready = 1'b1;
              w_load     = 1'b1;
            end else begin
              clk_en_o = 1'b0;
              w_nxt    = WAIT_FIFO;
            end
          end
        end
      end
      WAIT_FIFO: begin
        if (data_valid) begin
          data_ready = 1'b1;
          w_load     = 1'b1;
          w_nxt      = TRANSMIT;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_counter <= '0;
      r_trgt    <= SPI_CNT_RST_TRGT;
      r_sr      <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_cnt_clr)
        r_counter <= '0;
      else if (w_shift)
        r_counter <= r_counter + 1'b1;
      if (counter_in_upd)
        r_trgt <= en_quad_in ? {2'b00, counter_in[CNT_W-1:2]}
                             : counter_in;
      if (w_load)
        r_sr <= data;
      else if (w_shift)
        r_sr <= en_quad_in ? {r_sr[DATA_W-5:0], 4'b0000}
                           : {r_sr[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: table of transfers plus
// hand-written underrun, start-gating and mid-transfer reset cases.
module tb_spi_master_tx;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        tx_edge;
  logic        tx_done;
  logic        sdo0, sdo1, sdo2, sdo3;
  logic        en_quad_in;
  logic [15:0] counter_in;
  logic        counter_in_upd;
  logic [31:0] data;
  logic        data_valid;
  logic        data_ready;
  logic        clk_en_o;

  always #5 clk = ~clk;

  spi_master_tx dut (
    .clk            (clk),
    .rstn           (rstn),
    .en             (en),
    .tx_edge        (tx_edge),
    .tx_done        (tx_done),
    .sdo0           (sdo0),
    .sdo1           (sdo1),
    .sdo2           (sdo2),
    .sdo3           (sdo3),
    .en_quad_in     (en_quad_in),
    .counter_in     (counter_in),
    .counter_in_upd (counter_in_upd),
    .data           (data),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .clk_en_o       (clk_en_o)
  );

  // FIFO model: words pushed by the test, popped on data_ready
  logic [31:0] fifo_mem [16];
  int          fifo_wr = 0;
  int          fifo_rd = 0;
  logic        flush = 1'b0;

  assign data       = fifo_mem[fifo_rd[3:0]];
  assign data_valid = (fifo_rd != fifo_wr);

  always @(posedge clk) begin
    if (flush)
      fifo_rd <= fifo_wr;
    else if (rstn && data_ready)
      fifo_rd <= fifo_rd + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        quad;
    logic [15:0] cnt;
    logic [31:0] w0;
    logic [31:0] w1;
    int          nw;
    int          syms;
    int          pops;
    logic [63:0] exp;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    fifo_mem[fifo_wr[3:0]] = w;
    fifo_wr++;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // one tx_edge, sampling the combinational outputs mid-strobe
  task automatic pulse(output logic d, output logic r, output logic c);
    tx_edge = 1'b1;
    #1;
    d = tx_done;
    r = data_ready;
    c = clk_en_o;
    @(negedge clk);
    tx_edge = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_xfer(input logic q, input logic [15:0] cnt,
                            output int r0);
    counter_in     = cnt;
    en_quad_in     = q;
    counter_in_upd = 1'b1;
    @(negedge clk);
    counter_in_upd = 1'b0;
    en = 1'b1;
    #1;
    chk("start_pop", data_ready, 1);
    r0 = fifo_rd;
    @(negedge clk);
    en = 1'b0;
    chk("clk_en_run", clk_en_o, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int r0;
    logic d, r, c;
    logic [3:0] sym;
    push(v.w0);
    if (v.nw > 1) push(v.w1);
    start_xfer(v.quad, v.cnt, r0);
    for (int s = 0; s < v.syms; s++) begin
      sym = v.quad ? v.exp[63-4*s -: 4] : {3'b000, v.exp[63-s]};
      chk("sdo", {28'd0, sdo3, sdo2, sdo1, sdo0}, {28'd0, sym});
      pulse(d, r, c);
      chk("tx_done", d, (s == v.syms - 1));
    end
    chk("idle_clk_en", clk_en_o, 0);
    chk("pops", fifo_rd - r0, v.pops);
    chk("idle_state", dut.r_state, IDLE);
    do_flush();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   r0;
    logic d, r, c;

    vt[0] = '{1'b0, 16'd32, 32'hA5A5F00F, 32'h0, 1, 32, 1,
              64'hA5A5F00F_00000000};
    vt[1] = '{1'b1, 16'd64, 32'h12345678, 32'h9ABCDEF0, 2, 16, 2,
              64'h12345678_9ABCDEF0};
    vt[2] = '{1'b0, 16'd8, 32'hC3000000, 32'hDEADBEEF, 2, 8, 1,
              64'hC3000000_00000000};
    vt[3] = '{1'b0, 16'd40, 32'hF0F0F0F0, 32'hAB123456, 2, 40, 2,
              64'hF0F0F0F0_AB000000};
    vt[4] = '{1'b1, 16'd8, 32'h7E000000, 32'h0, 1, 2, 1,
              64'h7E000000_00000000};

    rstn = 1'b0;
    en = 1'b0;
    tx_edge = 1'b0;
    en_quad_in = 1'b0;
    counter_in = '0;
    counter_in_upd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sdo", {28'd0, sdo3, sdo2, sdo1, sdo0}, 0);
    chk("rst_clk_en", clk_en_o, 0);
    chk("rst_ready", data_ready, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_trgt", dut.r_trgt, 8);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // underrun between words
    push(32'h80000001);
    start_xfer(1'b0, 16'd64, r0);
    chk("ur_first", sdo0, 1);
    repeat (31) pulse(d, r, c);
    chk("ur_last", sdo0, 1);
    pulse(d, r, c);
    chk("ur_clk_en", c, 0);
    chk("ur_ready", r, 0);
    chk("ur_state", dut.r_state, WAIT_FIFO);
    pulse(d, r, c);
    chk("ur_edge_ign", dut.r_counter, 32);
    repeat (5) @(negedge clk);
    chk("ur_wait_clk", clk_en_o, 0);
    push(32'h40000000);
    #1;
    chk("ur_pop", data_ready, 1);
    @(negedge clk);
    chk("ur_resume", clk_en_o, 1);
    chk("ur_bit31", sdo0, 0);
    pulse(d, r, c);
    chk("ur_bit30", sdo0, 1);
    repeat (30) pulse(d, r, c);
    chk("ur_notdone", d, 0);
    pulse(d, r, c);
    chk("ur_done", d, 1);
    chk("ur_pops", fifo_rd - r0, 2);

    // start gating
    en = 1'b1;
    repeat (10) @(negedge clk);
    chk("gate_clk_en", clk_en_o, 0);
    chk("gate_state", dut.r_state, IDLE);
    counter_in = 16'd0;
    en_quad_in = 1'b0;
    counter_in_upd = 1'b1;
    @(negedge clk);
    counter_in_upd = 1'b0;
    push(32'h11111111);
    repeat (3) @(negedge clk);
    chk("zero_state", dut.r_state, IDLE);
    chk("zero_nopop", fifo_wr - fifo_rd, 1);
    en = 1'b0;
    do_flush();

    // reset in the middle of a transfer
    push(32'hFFFFFFFF);
    start_xfer(1'b0, 16'd32, r0);
    repeat (12) pulse(d, r, c);
    rstn = 1'b0;
    #1;
    chk("mr_sdo", {28'd0, sdo3, sdo2, sdo1, sdo0}, 0);
    chk("mr_clk_en", clk_en_o, 0);
    chk("mr_cnt", dut.r_counter, 0);
    chk("mr_trgt", dut.r_trgt, 8);
    @(negedge clk);
    rstn = 1'b1;
    do_flush();
    run_vec(vt[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
